// File: rtl/gpio_exc_pkg.sv
// Shared definitions for the GPIO / exception-capture peripheral:
// register offsets, EXC field layout, bus FSM states and byte-strobe helper.
package gpio_exc_pkg;

  localparam logic [31:0] OFF_OUT      = 32'h00;
  localparam logic [31:0] OFF_DIR      = 32'h04;
  localparam logic [31:0] OFF_IN       = 32'h08;
  localparam logic [31:0] OFF_IRQ_EN   = 32'h0C;
  localparam logic [31:0] OFF_IRQ_PEND = 32'h10;
  localparam logic [31:0] OFF_EXC      = 32'h14;
  localparam logic [31:0] OFF_SET      = 32'h18;
  localparam logic [31:0] OFF_CLR      = 32'h1C;

  localparam int EXC_VALID_BIT = 31;
  localparam int EXC_CNT_LSB   = 16;
  localparam int EXC_CNT_W     = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_e;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage input synchroniser followed by a previous-value register;
// o_rise flags a 0->1 transition of the synchronised value.
module gpio_sync_edge #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]             r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/gpio_exc_mmio.sv
// Memory-mapped GPIO with rising-edge interrupts plus sticky first-fault
// exception capture, on a simple valid/ready data bus (one transfer per 2 cycles).
module gpio_exc_mmio
  import gpio_exc_pkg::*;
#(
  parameter int GPIO_WIDTH  = 8,
  parameter int EXC_WIDTH   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  busValid,
  input  logic                  busWe,
  input  logic [ADDR_WIDTH-1:0] busAddr,
  input  logic [31:0]           busWData,
  input  logic [3:0]            busWStrb,
  output logic                  busReady,
  output logic [31:0]           busRData,
  input  logic [GPIO_WIDTH-1:0] gpioIn,
  output logic [GPIO_WIDTH-1:0] gpioOut,
  output logic [GPIO_WIDTH-1:0] gpioOe,
  output logic                  irq,
  input  logic                  excValid,
  input  logic [EXC_WIDTH-1:0]  excCode,
  input  logic                  excClear,
  output logic [EXC_WIDTH-1:0]  exceptionCode
);

  bus_state_e r_state, w_state_nxt;

  logic [GPIO_WIDTH-1:0] r_out, r_dir, r_en, r_pend;
  logic                  r_irq;
  logic [31:0]           r_rdata;
  logic                  r_exc_valid;
  logic [EXC_WIDTH-1:0]  r_exc_code;
  logic [EXC_CNT_W-1:0]  r_exc_cnt;

  logic                  w_accept, w_wr, w_exc_clr;
  logic [31:0]           w_off, w_bmask, w_rdata, w_exc_word;
  logic [GPIO_WIDTH-1:0] w_m, w_d, w_w1c, w_sync, w_rise;
  logic                  w_unused_bits;

  gpio_sync_edge #(
    .WIDTH  (GPIO_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .i_async (gpioIn),
    .o_sync  (w_sync),
    .o_rise  (w_rise)
  );

  assign w_accept  = (r_state == IDLE) && busValid;
  assign w_wr      = w_accept && busWe;
  assign w_off     = 32'({busAddr[ADDR_WIDTH-1:2], 2'b00});
  assign w_bmask   = strb_to_mask(busWStrb);
  assign w_m       = w_bmask[GPIO_WIDTH-1:0];
  assign w_d       = busWData[GPIO_WIDTH-1:0];
  assign w_w1c     = (w_wr && w_off == OFF_IRQ_PEND) ? (w_d & w_m) : '0;
  assign w_exc_clr = excClear ||
                     (w_wr && w_off == OFF_EXC && busWStrb[3] && busWData[EXC_VALID_BIT]);
  assign w_unused_bits = ^{busAddr[1:0], busWData, w_bmask};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (busValid) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_exc_word = '0;
    w_exc_word[EXC_VALID_BIT] = r_exc_valid;
    w_exc_word[EXC_CNT_LSB +: EXC_CNT_W] = r_exc_cnt;
    w_exc_word[EXC_WIDTH-1:0] = r_exc_code;
  end

  // Write-only registers and unmapped offsets fall through to zero.
  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_OUT:      w_rdata = 32'(r_out);
      OFF_DIR:      w_rdata = 32'(r_dir);
      OFF_IN:       w_rdata = 32'(w_sync);
      OFF_IRQ_EN:   w_rdata = 32'(r_en);
      OFF_IRQ_PEND: w_rdata = 32'(r_pend);
      OFF_EXC:      w_rdata = w_exc_word;
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out   <= '0;
      r_dir   <= '0;
      r_en    <= '0;
      r_pend  <= '0;
      r_irq   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_wr) begin
        case (w_off)
          OFF_OUT:    r_out <= (r_out & ~w_m) | (w_d & w_m);
          OFF_DIR:    r_dir <= (r_dir & ~w_m) | (w_d & w_m);
          OFF_IRQ_EN: r_en  <= (r_en & ~w_m) | (w_d & w_m);
          OFF_SET:    r_out <= r_out | (w_d & w_m);
          OFF_CLR:    r_out <= r_out & ~(w_d & w_m);
          default:    ;
        endcase
      end
      // A new edge outranks a same-cycle write-1-to-clear.
      r_pend  <= (r_pend & ~w_w1c) | (w_rise & r_en);
      r_irq   <= |r_pend;
      r_rdata <= (w_accept && !busWe) ? w_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exc_valid <= 1'b0;
      r_exc_code  <= '0;
      r_exc_cnt   <= '0;
    end else if (excValid) begin
      if (w_exc_clr || !r_exc_valid) begin
        r_exc_valid <= 1'b1;
        r_exc_code  <= excCode;
        r_exc_cnt   <= EXC_CNT_W'(1);
      end else if (r_exc_cnt != '1) begin
        r_exc_cnt   <= r_exc_cnt + EXC_CNT_W'(1);
      end
    end else if (w_exc_clr) begin
      r_exc_valid <= 1'b0;
      r_exc_code  <= '0;
      r_exc_cnt   <= '0;
    end
  end

  assign busReady      = (r_state == RESP);
  assign busRData      = (r_state == RESP) ? r_rdata : '0;
  assign gpioOut       = r_out;
  assign gpioOe        = r_dir;
  assign irq           = r_irq;
  assign exceptionCode = r_exc_valid ? r_exc_code : '0;

endmodule

// File: tb/tb_gpio_exc_mmio.sv
// Scoreboard bench for gpio_exc_mmio: bus expectations are queued at issue
// and compared when busReady appears.
module tb_gpio_exc_mmio;

  localparam int GW = 8;
  localparam int EW = 2;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busValid = 1'b0;
  logic          busWe = 1'b0;
  logic [AW-1:0] busAddr = '0;
  logic [31:0]   busWData = '0;
  logic [3:0]    busWStrb = '0;
  logic          busReady;
  logic [31:0]   busRData;
  logic [GW-1:0] gpioIn = '0;
  logic [GW-1:0] gpioOut;
  logic [GW-1:0] gpioOe;
  logic          irq;
  logic          excValid = 1'b0;
  logic [EW-1:0] excCode = '0;
  logic          excClear = 1'b0;
  logic [EW-1:0] exceptionCode;

  gpio_exc_mmio #(
    .GPIO_WIDTH  (GW),
    .EXC_WIDTH   (EW),
    .SYNC_STAGES (2),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .busValid      (busValid),
    .busWe         (busWe),
    .busAddr       (busAddr),
    .busWData      (busWData),
    .busWStrb      (busWStrb),
    .busReady      (busReady),
    .busRData      (busRData),
    .gpioIn        (gpioIn),
    .gpioOut       (gpioOut),
    .gpioOe        (gpioOe),
    .irq           (irq),
    .excValid      (excValid),
    .excCode       (excCode),
    .excClear      (excClear),
    .exceptionCode (exceptionCode)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          is_rd;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (rst && busReady) begin
      if (sb_q.size() == 0) begin
        check("stray_ready", 32'(busReady), 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.is_rd) check(e.tag, busRData, e.exp);
      end
    end
  end

  task automatic bus_xfer(input bit we, input logic [AW-1:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input logic [31:0] exp, input string tag);
    sb_t e;
    @(negedge clk);
    busValid = 1'b1;
    busWe    = we;
    busAddr  = addr;
    busWData = wd;
    busWStrb = strb;
    e.tag = tag; e.is_rd = !we; e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk); #1;
    busValid = 1'b0;
    busWe    = 1'b0;
    check({tag, "_rdy"}, 32'(busReady), 32'd1);
    @(posedge clk); #1;
    check({tag, "_rdy_end"}, 32'(busReady), 32'd0);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                    input string tag);
    bus_xfer(1'b1, addr, wd, strb, 32'd0, tag);
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [31:0] exp, input string tag);
    bus_xfer(1'b0, addr, 32'd0, 4'h0, exp, tag);
  endtask

  task automatic exc_evt(input logic [EW-1:0] c);
    @(negedge clk);
    excValid = 1'b1;
    excCode  = c;
    @(negedge clk);
    excValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 32'(gpioOut), 32'd0);
    check("rst_oe", 32'(gpioOe), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_exccode", 32'(exceptionCode), 32'd0);
    check("rst_ready", 32'(busReady), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    rd(5'h00, 32'h0, "rd_out0");
    rd(5'h04, 32'h0, "rd_dir0");
    rd(5'h10, 32'h0, "rd_pend0");
    rd(5'h14, 32'h0, "rd_exc0");

    wr(5'h00, 32'h0000_00A5, 4'b0001, "wr_out");
    check("out_a5", 32'(gpioOut), 32'hA5);
    wr(5'h18, 32'h0000_000F, 4'b1111, "wr_set");
    check("out_af", 32'(gpioOut), 32'hAF);
    wr(5'h1C, 32'h0000_0081, 4'b1111, "wr_clr");
    check("out_2e", 32'(gpioOut), 32'h2E);
    wr(5'h00, 32'h0000_FFFF, 4'b0000, "wr_nostrb");
    check("out_nostrb", 32'(gpioOut), 32'h2E);
    rd(5'h00, 32'h2E, "rd_out");
    wr(5'h04, 32'h0000_1234, 4'b0011, "wr_dir");
    check("oe_34", 32'(gpioOe), 32'h34);
    rd(5'h04, 32'h34, "rd_dir");
    rd(5'h18, 32'h0, "rd_set_wo");
    rd(5'h1C, 32'h0, "rd_clr_wo");

    wr(5'h0C, 32'h1, 4'b1111, "wr_en");
    @(negedge clk);
    gpioIn = 8'h01;
    repeat (3) @(posedge clk);
    #1 check("irq_before", 32'(irq), 32'd0);
    @(posedge clk);
    #1 check("irq_after", 32'(irq), 32'd1);
    rd(5'h10, 32'h1, "rd_pend_set");
    rd(5'h08, 32'h1, "rd_in");

    @(negedge clk);
    gpioIn = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    gpioIn = 8'h03;
    @(posedge clk);
    @(posedge clk);
    wr(5'h10, 32'h1, 4'b1111, "w1c_collide");
    rd(5'h10, 32'h1, "rd_pend_setwins");
    rd(5'h08, 32'h3, "rd_in3");
    wr(5'h0C, 32'h0, 4'b1111, "wr_en_off");
    rd(5'h10, 32'h1, "rd_pend_keep");
    check("irq_held", 32'(irq), 32'd1);
    wr(5'h10, 32'h1, 4'b1111, "w1c");
    rd(5'h10, 32'h0, "rd_pend_clr");
    check("irq_clr", 32'(irq), 32'd0);

    exc_evt(2'd2);
    exc_evt(2'd1);
    exc_evt(2'd3);
    check("exccode_first", 32'(exceptionCode), 32'd2);
    rd(5'h14, 32'h8003_0002, "rd_exc3");
    @(negedge clk);
    excValid = 1'b1;
    excCode  = 2'd1;
    repeat (300) @(negedge clk);
    excValid = 1'b0;
    rd(5'h14, 32'h80FF_0002, "rd_exc_sat");

    @(negedge clk);
    excClear = 1'b1;
    excValid = 1'b1;
    excCode  = 2'd1;
    @(negedge clk);
    excClear = 1'b0;
    excValid = 1'b0;
    rd(5'h14, 32'h8001_0001, "rd_exc_clr_evt");
    check("exccode_new", 32'(exceptionCode), 32'd1);
    wr(5'h14, 32'h8000_0000, 4'b1111, "wr_exc_clr");
    rd(5'h14, 32'h0, "rd_exc_cleared");
    check("exccode_cleared", 32'(exceptionCode), 32'd0);
    exc_evt(2'd3);
    @(negedge clk);
    excClear = 1'b1;
    @(negedge clk);
    excClear = 1'b0;
    rd(5'h14, 32'h0, "rd_exc_pinclr");

    wr(5'h0C, 32'h1, 4'b1111, "wr_en2");
    @(negedge clk);
    gpioIn = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    gpioIn = 8'h01;
    repeat (5) @(posedge clk);
    #1 check("irq_prereset", 32'(irq), 32'd1);
    exc_evt(2'd2);
    @(negedge clk);
    busValid = 1'b1;
    busWe    = 1'b0;
    busAddr  = 5'h00;
    @(posedge clk); #1;
    busValid = 1'b0;
    check("resp_before_rst", 32'(busReady), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_ready", 32'(busReady), 32'd0);
    check("arst_rdata", busRData, 32'd0);
    check("arst_out", 32'(gpioOut), 32'd0);
    check("arst_oe", 32'(gpioOe), 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_exccode", 32'(exceptionCode), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd(5'h00, 32'h0, "rd_out_postrst");
    wr(5'h00, 32'h0000_005A, 4'b0001, "wr_out_postrst");
    check("out_postrst", 32'(gpioOut), 32'h5A);

    repeat (2) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
